// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared constants, segment table and phase type for the display scanner
package sevenseg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    PH_GUARD,
    PH_SHOW
  } phase_t;

endpackage

// File: rtl/sevenseg_scan_if.sv
// rtl/sevenseg_scan_if.sv - display data inputs and scanned pin outputs of the scanner
interface sevenseg_scan_if;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  modport master (
    output en, digits, dp_in, blank,
    input  an, seg, dp, digit_idx, frame_tick
  );

  modport slave (
    input  en, digits, dp_in, blank,
    output an, seg, dp, digit_idx, frame_tick
  );
endinterface

// File: rtl/hex7seg_dec.sv
// rtl/hex7seg_dec.sv - combinational nibble to active-low seven-segment lookup
module hex7seg_dec
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/sevenseg_scan.sv
// rtl/sevenseg_scan.sv - 4-digit multiplexed seven-segment scanner with guard blanking and frame snapshot
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 1000
) (
  input  logic          clk,
  input  logic          rst_n,
  sevenseg_scan_if.slave bus
);

  localparam int            CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   snap_digits;
  logic [3:0]    snap_dp;
  logic [3:0]    snap_blank;

  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic [1:0]    didx_q;
  logic          tick_q;

  phase_t        phase;
  logic [3:0]    cur_nib;
  logic [6:0]    cur_seg;
  logic          lit;
  logic          slot_end;

  assign phase    = (cnt < CNT_GUARD) ? PH_GUARD : PH_SHOW;
  assign cur_nib  = snap_digits[{idx, 2'b00} +: 4];
  assign lit      = (phase == PH_SHOW) && !snap_blank[idx];
  assign slot_end = (cnt == CNT_MAX);

  hex7seg_dec u_dec (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= 2'd0;
      snap_digits <= 16'h0000;
      snap_dp     <= 4'h0;
      snap_blank  <= 4'h0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
      didx_q      <= 2'd0;
      tick_q      <= 1'b0;
    end else if (!bus.en) begin
      // Disable parks the scan at a frame start so re-enable reloads the snapshot
      cnt    <= '0;
      idx    <= 2'd0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
      dp_q   <= 1'b1;
      didx_q <= 2'd0;
      tick_q <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) begin
        idx <= idx + 2'd1;
      end
      if (cnt == '0 && idx == 2'd0) begin
        snap_digits <= bus.digits;
        snap_dp     <= bus.dp_in;
        snap_blank  <= bus.blank;
      end
      an_q   <= lit ? ~(4'b0001 << idx) : AN_OFF;
      seg_q  <= lit ? cur_seg : SEG_OFF;
      dp_q   <= lit ? ~snap_dp[idx] : 1'b1;
      didx_q <= idx;
      tick_q <= slot_end && (idx == 2'd3);
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.digit_idx  = didx_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb/tb_sevenseg_scan.sv - self-checking bench for sevenseg_scan against a frame-position model
module tb_sevenseg_scan;

  localparam int R = 8;
  localparam int G = 2;

  logic clk = 1'b0;
  logic rst_n;

  sevenseg_scan_if bus_if ();

  sevenseg_scan #(.REFRESH_DIV(R), .GUARD(G)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Model: position within the running scan since the last frame start
  int         run    = 0;
  int         last_p = -1;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_dp  = '0;
  logic [3:0]  m_bl  = '0;
  logic [3:0]  e_an  = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp  = 1'b1;
  logic [1:0]  e_idx = 2'd0;
  logic        e_tick = 1'b0;
  bit          e_idx_care = 1'b1;
  int          m_slot, m_off;
  logic [3:0]  m_nib;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run = 0; last_p = -1;
      m_dig = '0; m_dp = '0; m_bl = '0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_idx = 2'd0; e_tick = 1'b0;
      e_idx_care = 1'b1;
    end else if (!bus_if.en) begin
      run = 0; last_p = -1;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
      e_idx_care = 1'b0;
    end else begin
      m_slot = (run / R) % 4;
      m_off  = run % R;
      m_nib  = m_dig[m_slot*4 +: 4];
      if (m_off >= G && !m_bl[m_slot]) begin
        e_an  = 4'hF ^ (4'h1 << m_slot);
        e_seg = hex_tab[m_nib];
        e_dp  = !m_dp[m_slot];
      end else begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end
      e_idx      = 2'(m_slot);
      e_idx_care = 1'b1;
      e_tick     = (run % (4*R)) == (4*R - 1);
      if (run % (4*R) == 0) begin
        m_dig = bus_if.digits;
        m_dp  = bus_if.dp_in;
        m_bl  = bus_if.blank;
      end
      last_p = run;
      run++;
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_an", 16'(bus_if.an), 16'(e_an));
    chk("cyc_seg", 16'(bus_if.seg), 16'(e_seg));
    chk("cyc_dp", 16'(bus_if.dp), 16'(e_dp));
    chk("cyc_tick", 16'(bus_if.frame_tick), 16'(e_tick));
    if (e_idx_care) chk("cyc_idx", 16'(bus_if.digit_idx), 16'(e_idx));
    chk("inv_onehot", 16'($countones(~bus_if.an) <= 1), 16'd1);
    chk("inv_dark", 16'((bus_if.an != 4'hF) || (bus_if.seg == 7'h7F)), 16'd1);
  end

  task automatic goto_p(input int target);
    int n = 0;
    while (last_p != target && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (last_p != target) begin
      checks++; errors++;
      $display("FAIL goto_p: position %0d never reached, at %0d", target, last_p);
    end
  endtask

  task automatic expect_out(input string name, input logic [3:0] an, input logic [6:0] seg,
                            input logic dp);
    chk({name, "_an"}, 16'(bus_if.an), 16'(an));
    chk({name, "_seg"}, 16'(bus_if.seg), 16'(seg));
    chk({name, "_dp"}, 16'(bus_if.dp), 16'(dp));
  endtask

  task automatic measure_restart(input string name, input int lit_exp, input int tick_exp);
    int lit_at = 0;
    int tick_at = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (lit_at == 0 && bus_if.an != 4'hF) begin
        lit_at = k;
        chk({name, "_first_idx"}, 16'(bus_if.digit_idx), 16'd0);
      end
      if (bus_if.frame_tick && tick_at == 0) tick_at = k;
      if (tick_exp == 0 && lit_at != 0) break;
      if (tick_at != 0) break;
    end
    chk({name, "_first_lit_edge"}, 16'(lit_at), 16'(lit_exp));
    if (tick_exp != 0) chk({name, "_first_tick_edge"}, 16'(tick_at), 16'(tick_exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus_if.en = 1'b0; bus_if.digits = 16'h0000; bus_if.dp_in = 4'h0; bus_if.blank = 4'h0;
    #23;
    expect_out("reset", 4'hF, 7'h7F, 1'b1);
    chk("reset_idx", 16'(bus_if.digit_idx), 16'd0);
    chk("reset_tick", 16'(bus_if.frame_tick), 16'd0);

    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); bus_if.digits = 16'h1A80; bus_if.en = 1'b1;

    goto_p(3);  expect_out("s0", 4'b1110, 7'b1000000, 1'b1);
    goto_p(8);  expect_out("s1_guard0", 4'hF, 7'h7F, 1'b1);
    goto_p(9);  expect_out("s1_guard1", 4'hF, 7'h7F, 1'b1);
    goto_p(10); expect_out("s1", 4'b1101, 7'b0000000, 1'b1);
    goto_p(19); expect_out("s2", 4'b1011, 7'b0001000, 1'b1);
    goto_p(27); expect_out("s3", 4'b0111, 7'b1111001, 1'b1);
    goto_p(31); chk("tick_at_wrap", 16'(bus_if.frame_tick), 16'd1);
    goto_p(32); chk("tick_one_cycle", 16'(bus_if.frame_tick), 16'd0);

    // Change mid-slot 1 must not tear the current frame
    goto_p(41); bus_if.digits = 16'hFFFF;
    goto_p(43); expect_out("tear_s1", 4'b1101, 7'b0000000, 1'b1);
    goto_p(51); expect_out("tear_s2", 4'b1011, 7'b0001000, 1'b1);
    goto_p(59); expect_out("tear_s3", 4'b0111, 7'b1111001, 1'b1);
    goto_p(67); expect_out("tear_next", 4'b1110, 7'b0001110, 1'b1);

    bus_if.blank = 4'b0100; bus_if.dp_in = 4'b0001; bus_if.digits = 16'h1A80;
    goto_p(99);  expect_out("dp_s0", 4'b1110, 7'b1000000, 1'b0);
    goto_p(104); expect_out("dp_guard", 4'hF, 7'h7F, 1'b1);
    goto_p(107); expect_out("dp_s1", 4'b1101, 7'b0000000, 1'b1);
    goto_p(115); expect_out("blank_s2", 4'hF, 7'h7F, 1'b1);
    goto_p(118); bus_if.blank = 4'h0; bus_if.dp_in = 4'h0;

    goto_p(148); expect_out("pre_dis_s2", 4'b1011, 7'b0001000, 1'b1);
    bus_if.en = 1'b0;
    @(negedge clk); expect_out("dis", 4'hF, 7'h7F, 1'b1);
    chk("dis_tick", 16'(bus_if.frame_tick), 16'd0);
    repeat (4) @(negedge clk);
    bus_if.en = 1'b1;
    measure_restart("reen", G + 1, 4*R);

    goto_p(36);
    #2 rst_n = 1'b0;
    #1 expect_out("async_rst", 4'hF, 7'h7F, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    measure_restart("rst_rel", G + 1, 0);

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) bus_if.digits = 16'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        bus_if.dp_in = 4'($urandom);
        bus_if.blank = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
      end
      if (bus_if.en) bus_if.en = ($urandom_range(0, 99) >= 2);
      else           bus_if.en = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
